// File: rtl/rtc_bus_responder.sv
// rtc_bus_responder
//   Responder for the multiplexed address/data RTC bus. Emulates a small
//   V3023-style register file: an address phase latches a register pointer,
//   a write data phase stores into that register, and a read data phase
//   drives it back with an output enable. A local port gives the rest of the
//   chip direct access to the same registers.
//
// Ports
//   Clock_in   system clock
//   Reset      asynchronous active-low reset
//   A_D        0 = address phase, 1 = data phase
//   CS/WR/RD   active-low chip select, write and read strobes
//   Data_in    bus value driven by the master
//   Data_out   read data toward the master, qualified by Data_oe
//   Data_oe    1 while the responder drives the bus
//   Loc_addr   local register select
//   Loc_we     local write enable
//   Loc_wd     local write data
//   Loc_q      reg[Loc_addr], combinational
//   Addr_q     last latched bus address
//   Wr_strobe  1-cycle pulse per completed bus write
//   Rd_strobe  1-cycle pulse per completed bus read
//   Bus_err    1-cycle pulse on an illegal strobe combination or phase abort
//
// State    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no phase active, decoding synced strobes
// ST_ADDR  | address phase, Addr_q loaded on strobe release
// ST_WDATA | write data phase, register written on strobe release
// ST_RDATA | read data phase, Data_out/Data_oe driven until release

module rtc_bus_responder #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     Clock_in,
  input  logic                     Reset,
  input  logic                     A_D,
  input  logic                     CS,
  input  logic                     WR,
  input  logic                     RD,
  input  logic [DATA_W-1:0]        Data_in,
  output logic [DATA_W-1:0]        Data_out,
  output logic                     Data_oe,
  input  logic [$clog2(DEPTH)-1:0] Loc_addr,
  input  logic                     Loc_we,
  input  logic [DATA_W-1:0]        Loc_wd,
  output logic [DATA_W-1:0]        Loc_q,
  output logic [DATA_W-1:0]        Addr_q,
  output logic                     Wr_strobe,
  output logic                     Rd_strobe,
  output logic                     Bus_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = DATA_W + 4;
  // Strobes idle high so a reset pipeline never looks like an active phase.
  localparam logic [SW-1:0]     SYNC_RST = {1'b0, 3'b111, {DATA_W{1'b0}}};
  localparam logic [DATA_W:0]   LP_DEPTH = DEPTH[DATA_W:0];

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_WDATA, ST_RDATA} state_t;

  logic [SW-1:0]     r_sync [SYNC_STAGES];
  logic [DATA_W-1:0] r_regs [DEPTH];
  state_t            r_state;
  state_t            w_next;
  logic              r_hold;
  logic [DATA_W-1:0] r_addr_q;
  logic [DATA_W-1:0] r_data_out;
  logic              r_data_oe;
  logic              r_wr_strobe;
  logic              r_rd_strobe;
  logic              r_bus_err;

  logic              w_ad, w_cs, w_wr, w_rd;
  logic [DATA_W-1:0] w_data;
  logic [AW-1:0]     w_idx;
  logic              w_in_range;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_err, w_bus_we, w_addr_ld, w_wr_done, w_rd_done;

  // Data travels with the strobes so the release-cycle sample is coherent.
  always_ff @(posedge Clock_in or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= SYNC_RST;
    end else begin
      r_sync[0] <= {A_D, CS, WR, RD, Data_in};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_ad   = r_sync[SYNC_STAGES-1][DATA_W+3];
  assign w_cs   = r_sync[SYNC_STAGES-1][DATA_W+2];
  assign w_wr   = r_sync[SYNC_STAGES-1][DATA_W+1];
  assign w_rd   = r_sync[SYNC_STAGES-1][DATA_W];
  assign w_data = r_sync[SYNC_STAGES-1][DATA_W-1:0];

  assign w_idx      = r_addr_q[AW-1:0];
  assign w_in_range = {1'b0, r_addr_q} < LP_DEPTH;
  assign w_rd_data  = w_in_range ? r_regs[w_idx] : '0;

  always_comb begin
    w_next    = r_state;
    w_err     = 1'b0;
    w_bus_we  = 1'b0;
    w_addr_ld = 1'b0;
    w_wr_done = 1'b0;
    w_rd_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // After an error nothing is decoded until CS is seen high, so a
        // held illegal combination gives one Bus_err pulse, not a train.
        if (!w_cs && !r_hold) begin
          if (!w_wr && !w_rd)      w_err  = 1'b1;
          else if (!w_rd && !w_ad) w_err  = 1'b1;
          else if (!w_wr)          w_next = w_ad ? ST_WDATA : ST_ADDR;
          else if (!w_rd)          w_next = ST_RDATA;
        end
      end
      ST_ADDR: begin
        if (w_cs || w_wr) begin
          w_addr_ld = 1'b1;
          w_next    = ST_IDLE;
        end else if (w_ad) begin
          w_err  = 1'b1;
          w_next = ST_IDLE;
        end
      end
      ST_WDATA: begin
        if (w_cs || w_wr) begin
          w_bus_we  = w_in_range;
          w_wr_done = 1'b1;
          w_next    = ST_IDLE;
        end else if (!w_ad) begin
          w_err  = 1'b1;
          w_next = ST_IDLE;
        end
      end
      ST_RDATA: begin
        if (w_cs || w_rd) begin
          w_rd_done = 1'b1;
          w_next    = ST_IDLE;
        end else if (!w_ad) begin
          w_err  = 1'b1;
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock_in or negedge Reset) begin
    if (!Reset) begin
      r_state     <= ST_IDLE;
      r_hold      <= 1'b0;
      r_addr_q    <= '0;
      r_data_out  <= '0;
      r_data_oe   <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_rd_strobe <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_hold      <= w_err | (r_hold & ~w_cs);
      r_wr_strobe <= w_wr_done;
      r_rd_strobe <= w_rd_done;
      r_bus_err   <= w_err;
      r_data_oe   <= (w_next == ST_RDATA);
      r_data_out  <= (w_next == ST_RDATA) ? w_rd_data : '0;
      if (w_addr_ld) r_addr_q <= w_data;
    end
  end

  // Bus write is issued after the local write so it wins on the same index.
  always_ff @(posedge Clock_in or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else begin
      if (Loc_we)   r_regs[Loc_addr] <= Loc_wd;
      if (w_bus_we) r_regs[w_idx]    <= w_data;
    end
  end

  assign Loc_q     = r_regs[Loc_addr];
  assign Addr_q    = r_addr_q;
  assign Data_out  = r_data_out;
  assign Data_oe   = r_data_oe;
  assign Wr_strobe = r_wr_strobe;
  assign Rd_strobe = r_rd_strobe;
  assign Bus_err   = r_bus_err;

endmodule

// File: doc/rtc_bus_responder.md
Name: rtc_bus_responder

Overview:
- Responder side of the multiplexed address/data RTC bus (A_D, CS, WR, RD, all active-low strobes) driven by the Write_Read master.
- Decodes address phases and write/read data phases, and holds a small register file that emulates the V3023 register map.
- Drives read data back with an output enable.
- Used as an on-chip RTC stand-in and as the bus-side model for closed-loop checks of the master.

Parameters:
DATA_W, 8, bus and register width
DEPTH, 16, number of registers; address bits used = log2(DEPTH)
SYNC_STAGES, 2, flip-flop stages on strobes and data before decode (>=2)

Ports:
Clock_in  input  1  system clock, 100 MHz
Reset  input  1  asynchronous, active-low reset
A_D  input  1  0 = address phase, 1 = data phase
CS  input  1  chip select, active-low
WR  input  1  write strobe, active-low
RD  input  1  read strobe, active-low
Data_in  input  DATA_W  bus value driven by the master
Data_out  output  DATA_W  read data driven toward the master
Data_oe  output  1  1 = responder drives the bus
Loc_addr  input  log2(DEPTH)  local register select
Loc_we  input  1  local write enable
Loc_wd  input  DATA_W  local write data
Loc_q  output  DATA_W  reg[Loc_addr], combinational
Addr_q  output  DATA_W  last latched bus address
Wr_strobe  output  1  1-cycle pulse on each completed bus write
Rd_strobe  output  1  1-cycle pulse on each completed bus read
Bus_err  output  1  1-cycle pulse on an illegal strobe combination

Behaviour:
- Reset low (async): all registers, Addr_q and Data_out = 0; Data_oe, Wr_strobe, Rd_strobe and Bus_err = 0; FSM = IDLE.
- A_D, CS, WR and RD pass through SYNC_STAGES flops. Data_in passes through the same-depth pipeline so bus data stays cycle-aligned with the synced strobes. Decoding uses synced values only.
- FSM states: IDLE, ADDR, WDATA, RDATA.
- IDLE:
  - cs=0, wr=0, rd=1, ad=0 -> ADDR.
  - cs=0, wr=0, rd=1, ad=1 -> WDATA.
  - cs=0, rd=0, wr=1, ad=1 -> RDATA.
  - cs=0, wr=0, rd=0 -> Bus_err pulse; stay IDLE.
  - cs=0, rd=0, ad=0 (read during address phase) -> Bus_err pulse; stay IDLE.
- ADDR: on first cycle with cs=1 or wr=1, latch the pipelined data into Addr_q -> IDLE. The data used is the value aligned with the last low strobe cycle, i.e. the rising-edge sample.
- WDATA: on release (cs=1 or wr=1), write the aligned data to reg[Addr_q] if Addr_q < DEPTH, else discard. Pulse Wr_strobe in the same cycle either way -> IDLE.
- RDATA:
  - Data_oe=1 from the first RDATA cycle; Data_out = reg[Addr_q], or 0 if Addr_q >= DEPTH, updated every cycle.
  - On release: Data_oe=0 in that same cycle, Rd_strobe pulse -> IDLE.
  - Read latency from raw RD low to Data_oe=1 is SYNC_STAGES+1 cycles.
- Any phase: ad changing mid-phase -> abort to IDLE with Bus_err pulse; no write, no address update.
- Local port:
  - Loc_we writes reg[Loc_addr] on the clock edge.
  - Same-cycle collision with a bus write to the same index: bus write wins, local write dropped. Different indices: both performed.
  - Loc_q reflects the write on the next cycle.
- Addr_q holds its value across transactions and is overwritten only by a completed ADDR phase.
- Reset asserted mid-transaction aborts immediately; any pending write is not performed.
- Throughput: back-to-back transactions need >=1 synced idle cycle (cs=1) between phases; phases with no idle gap merge and are decoded per the state rules above.

Test Plan:
- Address+write: A_D=0, CS=WR=0 for 9 cycles with Data_in=0x05, release; then A_D=1, CS=WR=0 with Data_in=0x3C, release -> Addr_q=0x05, reg[5]=0x3C, one Wr_strobe pulse, Loc_addr=5 gives Loc_q=0x3C.
- Read: after the write above, address phase 0x05 then A_D=1, CS=RD=0 for 15 cycles -> Data_oe=1 exactly 3 cycles after RD falls with Data_out=0x3C; Data_oe=0 on the release cycle; one Rd_strobe pulse.
- Out-of-range: address 0x20, write 0xFF -> no register changes, Wr_strobe still pulses; read of 0x20 -> Data_out=0x00 with Data_oe=1.
- Illegal strobes: CS=WR=RD=0 with A_D=1 -> Bus_err pulse, FSM stays IDLE, no register change; A_D toggles 0->1 during an address phase -> Bus_err pulse, Addr_q unchanged.
- Collision: bus write 0xAA to reg[3] and Loc_we=1, Loc_addr=3, Loc_wd=0x55 in the same cycle -> reg[3]=0xAA; repeat with Loc_addr=4 -> reg[3]=0xAA and reg[4]=0x55.
- Async reset: drop Reset low mid-RDATA -> Data_oe=0 immediately; after release all registers read 0x00 and Addr_q=0x00.
